// File: rtl/uart_pos_rx.sv
// 8N1 UART receiver packing four bytes little-endian into a position word.
// Ports: clk, rst (async high), rx in; uart_buf, buf_valid, frame_err, rx_busy out.
module uart_pos_rx #(
  parameter int CLKS_PER_BIT = 219,
  parameter int TIMEOUT_CLKS = 4380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] uart_buf,
  output logic        buf_valid,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] TMO_M1  = OW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          meta_q, rxs_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [23:0]   stage_q, stage_d;
  logic [1:0]    idx_q, idx_d;
  logic [OW-1:0] tmo_q, tmo_d;
  logic [31:0]   buf_q, buf_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;

  assign uart_buf  = buf_q;
  assign buf_valid = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a start edge takes priority over a coincident timeout
        if (!rxs_q) begin
          state_d = START;
          tmr_d   = '0;
          bit_d   = '0;
        end else if (idx_q != 2'd0) begin
          if (tmo_q == TMO_M1) begin
            idx_d = 2'd0;
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + OW'(1);
          end
        end
      end
      START: begin
        if (tmr_q == HALF_M1) begin
          tmr_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DATA: begin
        if (tmr_q == FULL_M1) begin
          tmr_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      STOP: begin
        if (tmr_q == FULL_M1) begin
          tmr_d = '0;
          tmo_d = '0;
          if (rxs_q) begin
            state_d = IDLE;
            idx_d   = idx_q + 2'd1;
            unique case (idx_q)
              2'd0: stage_d[7:0]   = shift_q;
              2'd1: stage_d[15:8]  = shift_q;
              2'd2: stage_d[23:16] = shift_q;
              2'd3: begin
                buf_d   = {shift_q, stage_q};
                valid_d = 1'b1;
              end
            endcase
          end else begin
            state_d = BREAK;
            idx_d   = 2'd0;
            ferr_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stage_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      rxs_q   <= meta_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: doc/uart_pos_rx.md
Name: uart_pos_rx

Overview:
- Serial-side producer of the 32-bit position word consumed by the renderer: x = uart_buf[15:0], y = uart_buf[31:16].
- Receives 8N1 UART bytes on a single rx pin and packs four consecutive bytes little-endian.
- Publishes each complete word atomically, so the renderer never sees a half-updated position.
- Sits in the pixel clock domain, between the board rx pin and the render block.

Parameters:
- CLKS_PER_BIT, 219, clk cycles per UART bit (25.2 MHz / 115200, rounded); must be >= 8.
- TIMEOUT_CLKS, 4380, idle clk cycles after a stop bit before a partial word is discarded (about 20 bit times).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  asynchronous UART line; idles high.
- uart_buf  out  32  last complete position word; {y[15:0], x[15:0]}.
- buf_valid  out  1  one-cycle pulse in the cycle uart_buf takes a new word.
- frame_err  out  1  one-cycle pulse when a stop bit samples low.
- rx_busy  out  1  high while the FSM is in any state other than IDLE.

Behaviour:
- Reset values: uart_buf=32'h0, buf_valid=0, frame_err=0, rx_busy=0, FSM=IDLE, byte_idx=0, synchroniser flops=1. All outputs are registered.
- rx passes through a 2-flop synchroniser; all logic below uses the synchronised value rxs.
- IDLE: rxs==0 -> START, bit counter cleared.
- START: wait CLKS_PER_BIT/2 cycles (integer division), then sample rxs.
  - rxs==1: glitch; go back to IDLE, no pulse.
  - rxs==0: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into a byte shift register. After the 8th sample -> STOP.
- STOP: sample rxs after CLKS_PER_BIT cycles.
  - rxs==1 (good byte): write the byte to lane byte_idx of the staging register; byte_idx++ (2-bit counter, wraps 3->0); reset the timeout counter; go to IDLE.
  - rxs==0: pulse frame_err; discard the byte; clear byte_idx; go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. A held-low line does not generate repeated bytes or errors.
- Completing a word: when a good byte lands in lane 3, uart_buf <= {byte3, byte2, byte1, byte0} and buf_valid=1, in the cycle after the stop-bit sample. Latency: stop-bit sample + 1 clk.
- uart_buf is never partially written and holds its value indefinitely between words.
- Timeout:
  - The idle counter runs in IDLE only while byte_idx!=0.
  - At TIMEOUT_CLKS it clears byte_idx; staging contents become don't-care; no pulse.
  - If a start edge and the timeout terminal count land in the same cycle, the start edge wins and the timeout is not applied.
- Reset mid-frame: everything returns to reset values immediately; any partial byte or word is lost.
- Counter widths: $clog2(CLKS_PER_BIT) for the bit timer, 3 bits for the bit index, $clog2(TIMEOUT_CLKS+1) for the timeout counter.
- buf_valid and frame_err are never high in the same cycle.

Test Plan (bench overrides CLKS_PER_BIT=16, TIMEOUT_CLKS=320):
- Reset -> uart_buf=0, all pulses low; send bytes 0x40,0x01,0x20,0x00 -> exactly one buf_valid, uart_buf=32'h0020_0140 (x=320, y=32), one clk after the 4th stop-bit sample.
- Send 3 bytes, idle 400 clks, then send 0x11,0x22,0x33,0x44 -> uart_buf=32'h4433_2211; no buf_valid during the idle gap.
- Second byte sent with stop bit=0 -> frame_err pulses once; uart_buf unchanged; next 4 good bytes 0xAA,0xBB,0xCC,0xDD -> uart_buf=32'hDDCC_BBAA.
- 5-clk low glitch on rx -> no byte counted, rx_busy returns low, no pulses; a following 4-byte word is received correctly.
- Hold rx low for 1000 clks, then send 4 bytes -> exactly one frame_err; word received correctly; byte shift is LSB-first (0x01 lands as uart_buf[0]=1).
- Assert rst in the middle of byte 2, release, send 4 bytes -> uart_buf equals exactly those 4 bytes and buf_valid pulses once.
